// File: rtl/recog_frame_sequencer_if.sv
// Bundle between the frame sequencer and the recognition pipeline: bbox/class in, ROI window and vote result out.
interface recog_frame_sequencer_if;
  logic [11:0] hcount_l1;
  logic [11:0] hcount_r1;
  logic [11:0] vcount_l1;
  logic [11:0] vcount_r1;
  logic [3:0]  sort_in;
  logic [11:0] hcount_l;
  logic [11:0] hcount_r;
  logic [11:0] vcount_l;
  logic [11:0] vcount_r;
  logic        proj_en;
  logic [3:0]  sort_out;
  logic        sort_valid;
  logic [1:0]  state;

  modport master (
    input  hcount_l1, hcount_r1, vcount_l1, vcount_r1, sort_in,
    output hcount_l, hcount_r, vcount_l, vcount_r, proj_en, sort_out, sort_valid, state
  );

  modport slave (
    output hcount_l1, hcount_r1, vcount_l1, vcount_r1, sort_in,
    input  hcount_l, hcount_r, vcount_l, vcount_r, proj_en, sort_out, sort_valid, state
  );
endinterface

// File: rtl/recog_frame_sequencer.sv
// Frame-level ROI tracker and class vote debouncer for the fruit recognition pipeline.
// Optional feature macro: ROI_MARGIN_EN (grow the loaded ROI by MARGIN on each side, clamped to the frame).
module recog_frame_sequencer #(
  parameter int IMG_W    = 800,
  parameter int IMG_H    = 600,
  parameter int VOTE_N   = 8,
  parameter int VOTE_MIN = 5,
  parameter int MISS_MAX = 3,
  parameter int MIN_SIZE = 16,
  parameter int MARGIN   = 8
) (
  input  logic pixelclk,
  input  logic reset_n,
  input  logic start,
  input  logic i_vsync,
  recog_frame_sequencer_if.master bus
);
  localparam int BW = $clog2(VOTE_N + 1);
  localparam logic [BW:0]  VOTE_MIN_W = (BW + 1)'(VOTE_MIN);
  localparam logic [4:0]   VOTE_N_W   = 5'(VOTE_N);
  localparam logic [4:0]   MISS_MAX_W = 5'(MISS_MAX);
  localparam logic [12:0]  MIN_SIZE_W = 13'(MIN_SIZE);
  localparam logic [11:0]  FULL_R     = 12'(IMG_W - 1);
  localparam logic [11:0]  FULL_B     = 12'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_TRACK  = 2'd2,
    S_DECIDE = 2'd3
  } state_t;

  state_t         state_reg;
  logic           vsync_d_reg;
  logic           fb_reg;
  logic           pend_reg;
  logic [11:0]    roi_l_reg, roi_r_reg, roi_t_reg, roi_b_reg;
  logic           proj_en_reg;
  logic [3:0]     sort_out_reg;
  logic           sort_valid_reg;
  logic [BW-1:0]  bin_reg [0:15];
  logic [3:0]     frame_cnt_reg;
  logic [3:0]     miss_cnt_reg;
  logic [4:0]     scan_cnt_reg;
  logic [BW-1:0]  max_val_reg;
  logic [3:0]     max_idx_reg;

  logic           bbox_valid;
  logic [11:0]    load_l, load_r, load_t, load_b;
  logic [12:0]    bbox_w, bbox_h;

  assign bbox_w = {1'b0, bus.hcount_r1} - {1'b0, bus.hcount_l1} + 13'd1;
  assign bbox_h = {1'b0, bus.vcount_r1} - {1'b0, bus.vcount_l1} + 13'd1;
  assign bbox_valid = (bus.hcount_r1 > bus.hcount_l1) && (bus.vcount_r1 > bus.vcount_l1) &&
                      (bbox_w >= MIN_SIZE_W) && (bbox_h >= MIN_SIZE_W);

`ifdef ROI_MARGIN_EN
  logic [12:0] sum_r, sum_b;
  assign sum_r  = {1'b0, bus.hcount_r1} + 13'(MARGIN);
  assign sum_b  = {1'b0, bus.vcount_r1} + 13'(MARGIN);
  // Low side saturates at 0 and high side at the last pixel/line, so nothing wraps in 12 bits.
  assign load_l = (bus.hcount_l1 > 12'(MARGIN)) ? bus.hcount_l1 - 12'(MARGIN) : 12'd0;
  assign load_t = (bus.vcount_l1 > 12'(MARGIN)) ? bus.vcount_l1 - 12'(MARGIN) : 12'd0;
  assign load_r = (sum_r > {1'b0, FULL_R}) ? FULL_R : sum_r[11:0];
  assign load_b = (sum_b > {1'b0, FULL_B}) ? FULL_B : sum_b[11:0];
`else
  assign load_l = bus.hcount_l1;
  assign load_r = bus.hcount_r1;
  assign load_t = bus.vcount_l1;
  assign load_b = bus.vcount_r1;
`endif

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      vsync_d_reg    <= 1'b0;
      fb_reg         <= 1'b0;
      pend_reg       <= 1'b0;
      roi_l_reg      <= 12'd0;
      roi_r_reg      <= FULL_R;
      roi_t_reg      <= 12'd0;
      roi_b_reg      <= FULL_B;
      proj_en_reg    <= 1'b0;
      sort_out_reg   <= 4'd0;
      sort_valid_reg <= 1'b0;
      frame_cnt_reg  <= 4'd0;
      miss_cnt_reg   <= 4'd0;
      scan_cnt_reg   <= 5'd0;
      max_val_reg    <= '0;
      max_idx_reg    <= 4'd0;
      for (int i = 0; i < 16; i++) bin_reg[i] <= '0;
    end else begin
      vsync_d_reg    <= i_vsync;
      fb_reg         <= i_vsync & ~vsync_d_reg;
      sort_valid_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (fb_reg && start) begin
            state_reg   <= S_SEARCH;
            proj_en_reg <= 1'b1;
          end
        end

        S_SEARCH: begin
          if (fb_reg) begin
            if (!start) begin
              state_reg   <= S_IDLE;
              proj_en_reg <= 1'b0;
            end else if (bbox_valid) begin
              state_reg     <= S_TRACK;
              roi_l_reg     <= load_l;
              roi_r_reg     <= load_r;
              roi_t_reg     <= load_t;
              roi_b_reg     <= load_b;
              frame_cnt_reg <= 4'd0;
              miss_cnt_reg  <= 4'd0;
              for (int i = 0; i < 16; i++) bin_reg[i] <= '0;
            end
          end
        end

        S_TRACK: begin
          // A frame boundary deferred from the decision scan is serviced here exactly like a live one.
          if (fb_reg || pend_reg) begin
            pend_reg <= 1'b0;
            if (!start) begin
              state_reg     <= S_IDLE;
              proj_en_reg   <= 1'b0;
              roi_l_reg     <= 12'd0;
              roi_r_reg     <= FULL_R;
              roi_t_reg     <= 12'd0;
              roi_b_reg     <= FULL_B;
              frame_cnt_reg <= 4'd0;
              miss_cnt_reg  <= 4'd0;
              for (int i = 0; i < 16; i++) bin_reg[i] <= '0;
            end else begin
              if (bin_reg[bus.sort_in] != {BW{1'b1}})
                bin_reg[bus.sort_in] <= bin_reg[bus.sort_in] + 1'b1;
              frame_cnt_reg <= frame_cnt_reg + 4'd1;
              if (bbox_valid) begin
                roi_l_reg    <= load_l;
                roi_r_reg    <= load_r;
                roi_t_reg    <= load_t;
                roi_b_reg    <= load_b;
                miss_cnt_reg <= 4'd0;
              end else begin
                miss_cnt_reg <= miss_cnt_reg + 4'd1;
              end
              if (!bbox_valid && ({1'b0, miss_cnt_reg} + 5'd1 >= MISS_MAX_W)) begin
                state_reg     <= S_SEARCH;
                roi_l_reg     <= 12'd0;
                roi_r_reg     <= FULL_R;
                roi_t_reg     <= 12'd0;
                roi_b_reg     <= FULL_B;
                frame_cnt_reg <= 4'd0;
                miss_cnt_reg  <= 4'd0;
                for (int i = 0; i < 16; i++) bin_reg[i] <= '0;
              end else if ({1'b0, frame_cnt_reg} + 5'd1 >= VOTE_N_W) begin
                state_reg    <= S_DECIDE;
                scan_cnt_reg <= 5'd0;
                max_val_reg  <= '0;
                max_idx_reg  <= 4'd0;
              end
            end
          end
        end

        S_DECIDE: begin
          if (fb_reg) pend_reg <= 1'b1;
          if (scan_cnt_reg[4]) begin
            sort_out_reg   <= ({1'b0, max_val_reg} >= VOTE_MIN_W) ? max_idx_reg : 4'd0;
            sort_valid_reg <= 1'b1;
            frame_cnt_reg  <= 4'd0;
            state_reg      <= S_TRACK;
            for (int i = 0; i < 16; i++) bin_reg[i] <= '0;
          end else begin
            // Strict compare keeps the lowest index on ties.
            if (bin_reg[scan_cnt_reg[3:0]] > max_val_reg) begin
              max_val_reg <= bin_reg[scan_cnt_reg[3:0]];
              max_idx_reg <= scan_cnt_reg[3:0];
            end
            scan_cnt_reg <= scan_cnt_reg + 5'd1;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.hcount_l   = roi_l_reg;
  assign bus.hcount_r   = roi_r_reg;
  assign bus.vcount_l   = roi_t_reg;
  assign bus.vcount_r   = roi_b_reg;
  assign bus.proj_en    = proj_en_reg;
  assign bus.sort_out   = sort_out_reg;
  assign bus.sort_valid = sort_valid_reg;
  assign bus.state      = state_reg;
endmodule

// File: tb/tb_recog_frame_sequencer.sv
// Scoreboard bench for recog_frame_sequencer: directed frame scenarios followed by random frames.
// Honours ROI_MARGIN_EN in its reference model when the design is built with it.
module tb_recog_frame_sequencer;
  localparam int IMG_W = 800;
  localparam int IMG_H = 600;

  logic pixelclk = 1'b0;
  logic reset_n  = 1'b0;
  logic start    = 1'b0;
  logic i_vsync  = 1'b0;

  recog_frame_sequencer_if bus();

  recog_frame_sequencer dut (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .start    (start),
    .i_vsync  (i_vsync),
    .bus      (bus)
  );

  always #5 pixelclk = ~pixelclk;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  always @(posedge pixelclk) cyc <= cyc + 1;

  typedef struct {
    int     code;
    longint at;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: state 0 idle, 1 search, 2 track; votes kept as a plain list of class codes.
  int m_state;
  int m_vis;
  int m_roi[4];
  int m_votes[$];
  int m_miss;
  int m_sort;

  task automatic cmp(input string name, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  always @(negedge pixelclk) begin
    if (bus.sort_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_sort_valid: got pulse with sort_out=%0d, expected no pulse", bus.sort_out);
      end else begin
        mon_e = exp_q.pop_front();
        cmp("sort_out", longint'(bus.sort_out), mon_e.code);
        cmp("sort_valid_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic model_reset();
    m_state = 0;
    m_vis   = 0;
    m_roi   = '{0, IMG_W - 1, 0, IMG_H - 1};
    m_votes.delete();
    m_miss  = 0;
    m_sort  = 0;
    exp_q.delete();
  endtask

  task automatic model_load(input int l, input int r, input int t, input int b);
`ifdef ROI_MARGIN_EN
    m_roi[0] = (l - 8 < 0) ? 0 : l - 8;
    m_roi[1] = (r + 8 > IMG_W - 1) ? IMG_W - 1 : r + 8;
    m_roi[2] = (t - 8 < 0) ? 0 : t - 8;
    m_roi[3] = (b + 8 > IMG_H - 1) ? IMG_H - 1 : b + 8;
`else
    m_roi = '{l, r, t, b};
`endif
  endtask

  task automatic model_fb(input bit st, input int l, input int r, input int t, input int b,
                          input int s, input longint c0);
    bit valid;
    int cnt[16];
    int best;
    int bestc;
    valid = (r > l) && (b > t) && (r - l + 1 >= 16) && (b - t + 1 >= 16);
    case (m_state)
      0: if (st) m_state = 1;
      1: begin
        if (!st) m_state = 0;
        else if (valid) begin
          m_state = 2;
          model_load(l, r, t, b);
          m_votes.delete();
          m_miss = 0;
        end
      end
      default: begin
        if (!st) begin
          m_state = 0;
          m_roi   = '{0, IMG_W - 1, 0, IMG_H - 1};
          m_votes.delete();
          m_miss  = 0;
        end else begin
          m_votes.push_back(s);
          if (valid) begin
            model_load(l, r, t, b);
            m_miss = 0;
          end else begin
            m_miss++;
          end
          if (m_miss >= 3) begin
            m_state = 1;
            m_roi   = '{0, IMG_W - 1, 0, IMG_H - 1};
            m_votes.delete();
            m_miss  = 0;
          end else if (m_votes.size() >= 8) begin
            foreach (cnt[k]) cnt[k] = 0;
            foreach (m_votes[k]) cnt[m_votes[k]]++;
            best  = 0;
            bestc = 0;
            for (int k = 0; k < 16; k++)
              if (cnt[k] > bestc) begin
                bestc = cnt[k];
                best  = k;
              end
            m_sort = (bestc >= 5) ? best : 0;
            exp_q.push_back('{m_sort, c0 + 19});
            m_votes.delete();
            m_vis = 3;
            return;
          end
        end
      end
    endcase
    m_vis = m_state;
  endtask

  task automatic check_outputs(input string tag);
    cmp({tag, "_state"},      longint'(bus.state),      m_state);
    cmp({tag, "_hcount_l"},   longint'(bus.hcount_l),   m_roi[0]);
    cmp({tag, "_hcount_r"},   longint'(bus.hcount_r),   m_roi[1]);
    cmp({tag, "_vcount_l"},   longint'(bus.vcount_l),   m_roi[2]);
    cmp({tag, "_vcount_r"},   longint'(bus.vcount_r),   m_roi[3]);
    cmp({tag, "_proj_en"},    longint'(bus.proj_en),    (m_state != 0) ? 1 : 0);
    cmp({tag, "_sort_out"},   longint'(bus.sort_out),   m_sort);
    cmp({tag, "_sort_valid"}, longint'(bus.sort_valid), 0);
  endtask

  task automatic frame(input bit st, input int l, input int r, input int t, input int b,
                       input int s, input int gap, input bit chk_fb, input bit chk_gap);
    longint c0;
    @(negedge pixelclk);
    start         = st;
    bus.hcount_l1 = 12'(l);
    bus.hcount_r1 = 12'(r);
    bus.vcount_l1 = 12'(t);
    bus.vcount_r1 = 12'(b);
    bus.sort_in   = 4'(s);
    i_vsync       = 1'b1;
    c0            = cyc;
    model_fb(st, l, r, t, b, s, c0);
    repeat (2) @(negedge pixelclk);
    if (chk_fb) begin
      cmp("fb+1_state",    longint'(bus.state),    m_vis);
      cmp("fb+1_hcount_l", longint'(bus.hcount_l), m_roi[0]);
      cmp("fb+1_vcount_r", longint'(bus.vcount_r), m_roi[3]);
    end
    @(negedge pixelclk);
    i_vsync = 1'b0;
    repeat (gap) @(negedge pixelclk);
    if (chk_gap) check_outputs("frame");
  endtask

  task automatic do_reset();
    @(negedge pixelclk);
    reset_n = 1'b0;
    i_vsync = 1'b0;
    repeat (3) @(negedge pixelclk);
    reset_n = 1'b1;
    model_reset();
    check_outputs("reset");
  endtask

  int seq_a[8] = '{3, 3, 2, 3, 3, 3, 1, 3};
  int seq_b[8] = '{2, 2, 2, 2, 5, 5, 5, 5};

  initial begin
    int l, r, t, b, s, dom, kind, guard;
    bit st;
    bus.hcount_l1 = 12'd0;
    bus.hcount_r1 = 12'd0;
    bus.vcount_l1 = 12'd0;
    bus.vcount_r1 = 12'd0;
    bus.sort_in   = 4'd0;
    model_reset();
    do_reset();

    // T1: idle -> search -> track with ROI loaded from the bbox
    frame(1, 100, 300, 50, 250, 0, 25, 1, 1);
    frame(1, 100, 300, 50, 250, 0, 25, 1, 1);
    // T2: majority vote for class 3
    foreach (seq_a[i]) frame(1, 110 + i, 310, 60, 260, seq_a[i], 25, 1, 1);
    // T3: 4/4 tie below the minimum count yields 0
    foreach (seq_b[i]) frame(1, 120, 320 - i, 70, 270, seq_b[i], 25, 1, 1);
    // T4: three invalid boxes drop back to search with the full ROI
    repeat (3) frame(1, 0, 0, 0, 0, 0, 25, 1, 1);
    // T5: a frame boundary landing inside the decision scan is deferred
    frame(1, 200, 400, 100, 300, 4, 25, 1, 1);
    repeat (7) frame(1, 200, 400, 100, 300, 4, 25, 1, 1);
    frame(1, 200, 400, 100, 300, 4, 2, 1, 0);
    frame(1, 210, 410, 110, 310, 6, 25, 0, 1);
    repeat (7) frame(1, 220, 420, 120, 320, 6, 25, 1, 1);
    // T6: stop returns to idle; then a box touching the frame edges
    frame(0, 220, 420, 120, 320, 6, 25, 1, 1);
    frame(1, 3, 790, 2, 595, 0, 25, 1, 1);
    frame(1, 3, 790, 2, 595, 0, 25, 1, 1);

    dom = 5;
    for (int n = 0; n < 90; n++) begin
      st   = ($urandom_range(0, 19) != 0);
      kind = $urandom_range(0, 9);
      l    = $urandom_range(0, 780);
      t    = $urandom_range(0, 580);
      if (kind < 2) begin
        l = 0; r = 0; t = 0; b = 0;
      end else if (kind == 2) begin
        r = l + $urandom_range(0, 15);
        b = t + $urandom_range(14, 200);
      end else begin
        r = l + $urandom_range(15, 200);
        b = t + $urandom_range(15, 200);
      end
      if ($urandom_range(0, 9) == 0) dom = $urandom_range(0, 15);
      s = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : dom;
      frame(st, l, r, t, b, s, $urandom_range(22, 30), 1, 1);
    end

    // Reset in the middle of a decision scan must suppress the pending result.
    guard = 0;
    while (m_state != 2 && guard < 10) begin
      frame(1, 300, 500, 200, 400, 9, 25, 1, 1);
      guard++;
    end
    cmp("reach_track", m_state, 2);
    while (m_votes.size() < 7 && guard < 30) begin
      frame(1, 300, 500, 200, 400, 9, 25, 1, 1);
      guard++;
    end
    frame(1, 300, 500, 200, 400, 9, 2, 1, 0);
    repeat (6) @(negedge pixelclk);
    cmp("midscan_state", longint'(bus.state), 3);
    do_reset();
    repeat (30) @(negedge pixelclk);
    check_outputs("post_reset");

    cmp("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
